his_frame_sequencer: RTL and testbench

Frame-level controller for the per-RAM histogram memory of the SiFH dToF path. It sequences one frame in four phases: clear all bins, accumulate timestamp events by read-modify-write, scan each pixel's histogram for its peak, and report one peak per pixel over a valid/ready handshake. It owns both ports of the simple dual-port histogram RAM: port A writes, port B reads with 1-cycle latency, and a same-address read-during-write returns the old data.

---
 rtl/his_frame_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_his_frame_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/his_frame_sequencer.sv
// Frame sequencer for one histogram RAM: clear, accumulate, peak scan, report.
// Owns both RAM ports; port B reads with one-cycle latency and returns old data.
module his_frame_sequencer #(
    parameter int PIX_W = 2,
    parameter int BIN_W = 6,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic                   start,
    input  logic                   acq_end,
    input  logic                   evt_valid,
    input  logic [PIX_W-1:0]       evt_pixel,
    input  logic [BIN_W-1:0]       evt_bin,
    output logic                   evt_ready,
    output logic                   ram_wen,
    output logic [PIX_W+BIN_W-1:0] ram_waddr,
    output logic [CNT_W-1:0]       ram_wdata,
    output logic                   ram_ren,
    output logic [PIX_W+BIN_W-1:0] ram_raddr,
    input  logic [CNT_W-1:0]       ram_rdata,
    output logic                   pk_valid,
    input  logic                   pk_ready,
    output logic [PIX_W-1:0]       pk_pixel,
    output logic [BIN_W-1:0]       pk_bin,
    output logic [CNT_W-1:0]       pk_count,
    output logic                   busy,
    output logic                   done
);
    localparam int AW = PIX_W + BIN_W;
    localparam logic [CNT_W-1:0] CMAX = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ACQ, S_DRAIN, S_SCAN, S_REPORT, S_DONE
    } state_t;

    state_t            state;
    logic [AW-1:0]     clr_addr;
    logic              s1_valid, s2_valid, s3_valid;
    logic [AW-1:0]     s1_addr, s2_addr, s3_addr;
    logic [CNT_W-1:0]  s2_data, s3_data;
    logic [PIX_W-1:0]  pixel;
    logic [BIN_W-1:0]  rd_bin, rv_bin, max_bin;
    logic              rd_active, rv;
    logic [CNT_W-1:0]  max_cnt;

    logic              accept, scan_rd, clearing, gt;
    logic [AW-1:0]     evt_addr;
    logic [CNT_W-1:0]  old_cnt, inc_cnt;

    assign evt_ready = (state == S_ACQ);
    assign accept    = evt_valid & evt_ready;
    assign evt_addr  = {evt_pixel, evt_bin};
    assign scan_rd   = (state == S_SCAN) & rd_active;
    assign clearing  = (state == S_CLEAR);
    assign ram_ren   = accept | scan_rd;
    assign ram_wen   = clearing | s2_valid;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign gt        = (ram_rdata > max_cnt);

    // Read address: event lookup in ACQ, bin sweep in SCAN.
    always_comb begin
        ram_raddr = '0;
        if (accept)
            ram_raddr = evt_addr;
        else if (scan_rd)
            ram_raddr = {pixel, rd_bin};
    end

    // Write port: zero-fill during CLEAR, otherwise the pipelined increment.
    always_comb begin
        ram_waddr = '0;
        ram_wdata = '0;
        if (clearing)
            ram_waddr = clr_addr;
        else if (s2_valid) begin
            ram_waddr = s2_addr;
            ram_wdata = s2_data;
        end
    end

    // Old count: newest in-flight write to the same address beats RAM data.
    always_comb begin
        old_cnt = ram_rdata;
        if (s2_valid && s2_addr == s1_addr)
            old_cnt = s2_data;
        else if (s3_valid && s3_addr == s1_addr)
            old_cnt = s3_data;
        inc_cnt = (old_cnt == CMAX) ? CMAX : old_cnt + CNT_W'(1);
    end

    // Read-modify-write pipeline: s1 lookup, s2 write, s3 last write for forwarding.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s2_valid <= 1'b0;
            s2_addr  <= '0;
            s2_data  <= '0;
            s3_valid <= 1'b0;
            s3_addr  <= '0;
            s3_data  <= '0;
        end else begin
            s1_valid <= accept;
            s1_addr  <= evt_addr;
            s2_valid <= s1_valid;
            s2_addr  <= s1_addr;
            s2_data  <= inc_cnt;
            s3_valid <= s2_valid;
            s3_addr  <= s2_addr;
            s3_data  <= s2_data;
        end
    end

    // Frame FSM with peak scan and registered report outputs.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state     <= S_IDLE;
            clr_addr  <= '0;
            pixel     <= '0;
            rd_bin    <= '0;
            rd_active <= 1'b0;
            rv        <= 1'b0;
            rv_bin    <= '0;
            max_cnt   <= '0;
            max_bin   <= '0;
            pk_valid  <= 1'b0;
            pk_pixel  <= '0;
            pk_bin    <= '0;
            pk_count  <= '0;
        end else begin
            rv     <= scan_rd;
            rv_bin <= rd_bin;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_CLEAR;
                        clr_addr <= '0;
                    end
                end
                S_CLEAR: begin
                    clr_addr <= clr_addr + AW'(1);
                    if (&clr_addr)
                        state <= S_ACQ;
                end
                S_ACQ: begin
                    if (acq_end)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!s1_valid && !s2_valid) begin
                        state     <= S_SCAN;
                        pixel     <= '0;
                        rd_bin    <= '0;
                        rd_active <= 1'b1;
                        max_cnt   <= '0;
                        max_bin   <= '0;
                    end
                end
                S_SCAN: begin
                    if (rd_active) begin
                        rd_bin <= rd_bin + BIN_W'(1);
                        if (&rd_bin)
                            rd_active <= 1'b0;
                    end
                    if (rv) begin
                        if (gt) begin
                            max_cnt <= ram_rdata;
                            max_bin <= rv_bin;
                        end
                        if (&rv_bin) begin
                            state    <= S_REPORT;
                            pk_valid <= 1'b1;
                            pk_pixel <= pixel;
                            pk_bin   <= gt ? rv_bin : max_bin;
                            pk_count <= gt ? ram_rdata : max_cnt;
                        end
                    end
                end
                S_REPORT: begin
                    if (pk_ready) begin
                        pk_valid <= 1'b0;
                        if (&pixel)
                            state <= S_DONE;
                        else begin
                            state     <= S_SCAN;
                            pixel     <= pixel + PIX_W'(1);
                            rd_bin    <= '0;
                            rd_active <= 1'b1;
                            max_cnt   <= '0;
                            max_bin   <= '0;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_his_frame_sequencer.sv
// Directed bench for his_frame_sequencer with a behavioural dual-port RAM.
// Expected peaks and RAM counts are hand-computed from the event lists.
module tb_his_frame_sequencer;
    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       start = 1'b0;
    logic       acq_end = 1'b0;
    logic       evt_valid = 1'b0;
    logic [1:0] evt_pixel = '0;
    logic [5:0] evt_bin = '0;
    logic       evt_ready;
    logic       ram_wen;
    logic [7:0] ram_waddr;
    logic [7:0] ram_wdata;
    logic       ram_ren;
    logic [7:0] ram_raddr;
    logic [7:0] ram_rdata;
    logic       pk_valid;
    logic       pk_ready = 1'b1;
    logic [1:0] pk_pixel;
    logic [5:0] pk_bin;
    logic [7:0] pk_count;
    logic       busy;
    logic       done;

    logic [7:0] mem [256];
    int total = 0;
    int bad = 0;
    int rb [4];
    int rc [4];
    int nrep;
    int ndone;

    his_frame_sequencer dut (
        .clk(clk), .res(res), .start(start), .acq_end(acq_end),
        .evt_valid(evt_valid), .evt_pixel(evt_pixel), .evt_bin(evt_bin),
        .evt_ready(evt_ready), .ram_wen(ram_wen), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata), .ram_ren(ram_ren), .ram_raddr(ram_raddr),
        .ram_rdata(ram_rdata), .pk_valid(pk_valid), .pk_ready(pk_ready),
        .pk_pixel(pk_pixel), .pk_bin(pk_bin), .pk_count(pk_count),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Simple dual-port RAM, read-during-write returns old data.
    always @(posedge clk) begin
        if (ram_ren) ram_rdata <= mem[ram_raddr];
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic do_start();
        int errs;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        errs = 0;
        for (int i = 0; i < 256; i++) begin
            if (!ram_wen || ram_waddr != 8'(i) || ram_wdata != 0 || evt_ready)
                errs++;
            @(negedge clk);
        end
        chk("clear_seq", errs, 0);
        chk("rdy_after_clear", evt_ready, 1);
    endtask

    task automatic evt(input int p, input int b);
        evt_valid = 1'b1;
        evt_pixel = 2'(p);
        evt_bin = 6'(b);
        @(negedge clk);
    endtask

    task automatic end_acq();
        evt_valid = 1'b0;
        acq_end = 1'b1;
        @(negedge clk);
        acq_end = 1'b0;
    endtask

    task automatic collect(input bit stall);
        int herr;
        logic [1:0] hp;
        logic [5:0] hb;
        logic [7:0] hc;
        nrep = 0;
        ndone = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (pk_valid) begin
                if (stall && nrep == 0) begin
                    hp = pk_pixel;
                    hb = pk_bin;
                    hc = pk_count;
                    herr = 0;
                    repeat (10) begin
                        @(negedge clk);
                        if (!pk_valid || pk_pixel != hp || pk_bin != hb ||
                            pk_count != hc || ram_ren)
                            herr++;
                    end
                    chk("hold_stable", herr, 0);
                    pk_ready = 1'b1;
                end
                rb[pk_pixel] = pk_bin;
                rc[pk_pixel] = pk_count;
                nrep++;
            end
            if (done) ndone++;
            if (ndone > 0 && !busy) break;
        end
        chk("frame_end_idle", busy, 0);
        chk("reports", nrep, 4);
        chk("done_pulses", ndone, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ready", evt_ready, 0);
        chk("rst_wen", ram_wen, 0);
        chk("rst_ren", ram_ren, 0);
        chk("rst_pkv", pk_valid, 0);
        chk("rst_done", done, 0);
        res = 1'b0;
        @(negedge clk);

        // Frame 1: single event
        do_start();
        evt(1, 10);
        end_acq();
        pk_ready = 1'b1;
        collect(1'b0);
        chk("f1_p0_bin", rb[0], 0);
        chk("f1_p0_cnt", rc[0], 0);
        chk("f1_p1_bin", rb[1], 10);
        chk("f1_p1_cnt", rc[1], 1);
        chk("f1_p3_cnt", rc[3], 0);

        // Frame 2: forwarding, saturation, ties, stalled report
        @(negedge clk);
        do_start();
        repeat (300) evt(0, 5);
        for (int k = 0; k < 4; k++) begin
            evt(1, 9);
            evt(1, 3);
        end
        repeat (5) evt(2, 7);
        evt(2, 7);
        evt(2, 8);
        evt(2, 7);
        evt(2, 8);
        evt(2, 7);
        evt_valid = 1'b1;
        evt_pixel = 2'd2;
        evt_bin = 6'd8;
        acq_end = 1'b1;
        @(negedge clk);
        acq_end = 1'b0;
        chk("rdy_drop", evt_ready, 0);
        evt_pixel = 2'd3;
        evt_bin = 6'd1;
        repeat (3) @(negedge clk);
        evt_valid = 1'b0;
        pk_ready = 1'b0;
        collect(1'b1);
        chk("f2_p0_bin", rb[0], 5);
        chk("f2_p0_sat", rc[0], 255);
        chk("f2_p1_tie_bin", rb[1], 3);
        chk("f2_p1_cnt", rc[1], 4);
        chk("f2_p2_bin", rb[2], 7);
        chk("f2_p2_cnt", rc[2], 8);
        chk("f2_p3_drop", rc[3], 0);
        chk("f2_ram_2_8", mem[8'd136], 3);
        chk("f2_ram_0_5", mem[8'd5], 255);

        // Frame 3: reset during ACQ
        @(negedge clk);
        do_start();
        repeat (3) evt(1, 1);
        evt_valid = 1'b0;
        res = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", evt_ready, 0);
        chk("mid_rst_wen", ram_wen, 0);
        chk("mid_rst_ren", ram_ren, 0);
        chk("mid_rst_waddr", ram_waddr, 0);
        chk("mid_rst_raddr", ram_raddr, 0);
        chk("mid_rst_pkv", pk_valid, 0);
        @(negedge clk);
        res = 1'b0;
        @(negedge clk);

        // Frame 4: clean frame after abort
        do_start();
        evt(3, 20);
        evt(1, 1);
        evt(3, 20);
        end_acq();
        pk_ready = 1'b1;
        collect(1'b0);
        chk("f4_p0_cnt", rc[0], 0);
        chk("f4_p1_bin", rb[1], 1);
        chk("f4_p1_cnt", rc[1], 1);
        chk("f4_p2_cnt", rc[2], 0);
        chk("f4_p3_bin", rb[3], 20);
        chk("f4_p3_cnt", rc[3], 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
